// File: rtl/des_key_sched_seq_if.sv
// des_key_sched_seq_if: key-schedule bundle; master drives start/decrypt/key_in/rk_ready, slave returns rk_valid/rk_data/rk_idx/rk_last/busy/done/cd_out
interface des_key_sched_seq_if;
  logic        start;
  logic        decrypt;
  logic [55:0] key_in;
  logic        rk_valid;
  logic        rk_ready;
  logic [47:0] rk_data;
  logic [3:0]  rk_idx;
  logic        rk_last;
  logic        busy;
  logic        done;
  logic [55:0] cd_out;
  modport master (
    output start, decrypt, key_in, rk_ready,
    input  rk_valid, rk_data, rk_idx, rk_last, busy, done, cd_out
  );
  modport slave (
    input  start, decrypt, key_in, rk_ready,
    output rk_valid, rk_data, rk_idx, rk_last, busy, done, cd_out
  );
endinterface

// File: rtl/des_key_sched_seq.sv
// des_key_sched_seq: rotating C/D register + PC-2 streaming DES round keys (clk, rst, bus: start/decrypt/key_in in, rk_* stream and busy/done/cd_out out)
module p_box_56_48 (
  input  logic [55:0] i_cd,
  output logic [47:0] o_rk
);
  localparam int P [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };
  for (genvar k = 0; k < 48; k++) begin : g_bit
    assign o_rk[47-k] = i_cd[56-P[k]];
  end
endmodule

module des_key_sched_seq #(
  parameter int          ROUNDS     = 16,
  parameter logic [15:0] SHIFT_MASK = 16'h8103
) (
  input logic               clk,
  input logic               rst,
  des_key_sched_seq_if.slave bus
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;
  function automatic int unsigned sh(input logic [3:0] r);
    return SHIFT_MASK[r] ? 32'd1 : 32'd2;
  endfunction
  function automatic int unsigned tot();
    int unsigned t;
    t = 0;
    for (int r = 0; r < ROUNDS; r++) t += sh(4'(r));
    return t;
  endfunction
  localparam int unsigned DEC_LOAD = tot() % 28;
  function automatic logic [27:0] rotl(input logic [27:0] x, input int unsigned n);
    logic [55:0] t;
    t = {x, x} << n;
    return t[55:28];
  endfunction
  function automatic logic [55:0] rot_cd(input logic [55:0] cd, input int unsigned n);
    return {rotl(cd[55:28], n), rotl(cd[27:0], n)};
  endfunction
  logic [0:0]  r_state;
  logic        r_mode;
  logic        r_done;
  logic [3:0]  r_idx;
  logic [55:0] r_cd;
  logic        w_last;
  logic [55:0] w_cd_load;
  logic [55:0] w_cd_step;
  logic [47:0] w_rk;
  assign w_last    = r_idx == 4'(ROUNDS - 1);
  assign w_cd_load = rot_cd(bus.key_in, bus.decrypt ? DEC_LOAD : sh(4'd0));
  assign w_cd_step = rot_cd(r_cd, r_mode ? 32'd28 - sh(4'(ROUNDS - 1) - r_idx) : sh(r_idx + 4'd1));
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_mode  <= 1'b0;
      r_done  <= 1'b0;
      r_idx   <= '0;
      r_cd    <= '0;
    end else begin
      r_done <= 1'b0;
      if (r_state == IDLE) begin
        if (bus.start) begin
          r_state <= RUN;
          r_mode  <= bus.decrypt;
          r_idx   <= '0;
          r_cd    <= w_cd_load;
        end
      end else if (bus.rk_ready) begin
        if (w_last) begin
          r_state <= IDLE;
          r_done  <= 1'b1;
        end else begin
          r_idx <= r_idx + 4'd1;
          r_cd  <= w_cd_step;
        end
      end
    end
  end
  p_box_56_48 u_pc2 (.i_cd(r_cd), .o_rk(w_rk));
  assign bus.rk_data  = w_rk;
  assign bus.rk_valid = r_state == RUN;
  assign bus.busy     = r_state == RUN;
  assign bus.rk_idx   = r_idx;
  assign bus.rk_last  = (r_state == RUN) && w_last;
  assign bus.done     = r_done;
  assign bus.cd_out   = r_cd;
endmodule

// File: tb/tb_des_key_sched_seq.sv
// tb_des_key_sched_seq: directed checks of des_key_sched_seq in three configurations against a cumulative-shift model
module tb_des_key_sched_seq;
  localparam logic [55:0] K    = 56'hF0CCAAF556678F;
  localparam logic [55:0] K2   = 56'h0123456789ABCD;
  localparam logic [47:0] K1_E = 48'h1B02EFFC7072;
  localparam logic [47:0] K16_E = 48'hCB3D8B0E17F5;
  localparam int P [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };
  logic clk, rst, start, decrypt, rk_ready;
  logic [55:0] key_in;
  int n_vec, n_bad;
  logic [47:0] got [16];
  logic [47:0] enc [16];
  des_key_sched_seq_if ia ();
  des_key_sched_seq_if ib ();
  des_key_sched_seq_if ic ();
  des_key_sched_seq dut_a (.clk(clk), .rst(rst), .bus(ia.slave));
  des_key_sched_seq #(.ROUNDS(1), .SHIFT_MASK(16'h0001)) dut_b (.clk(clk), .rst(rst), .bus(ib.slave));
  des_key_sched_seq #(.ROUNDS(4), .SHIFT_MASK(16'h0000)) dut_c (.clk(clk), .rst(rst), .bus(ic.slave));
  assign ia.start = start;  assign ib.start = start;  assign ic.start = start;
  assign ia.decrypt = decrypt;  assign ib.decrypt = decrypt;  assign ic.decrypt = decrypt;
  assign ia.key_in = key_in;  assign ib.key_in = key_in;  assign ic.key_in = key_in;
  assign ia.rk_ready = rk_ready;  assign ib.rk_ready = rk_ready;  assign ic.rk_ready = rk_ready;
  logic        m_valid [3];
  logic        m_last  [3];
  logic        m_busy  [3];
  logic        m_done  [3];
  logic [47:0] m_data  [3];
  logic [3:0]  m_idx   [3];
  always_comb begin
    m_valid[0] = ia.rk_valid;  m_valid[1] = ib.rk_valid;  m_valid[2] = ic.rk_valid;
    m_last[0]  = ia.rk_last;   m_last[1]  = ib.rk_last;   m_last[2]  = ic.rk_last;
    m_busy[0]  = ia.busy;      m_busy[1]  = ib.busy;      m_busy[2]  = ic.busy;
    m_done[0]  = ia.done;      m_done[1]  = ib.done;      m_done[2]  = ic.done;
    m_data[0]  = ia.rk_data;   m_data[1]  = ib.rk_data;   m_data[2]  = ic.rk_data;
    m_idx[0]   = ia.rk_idx;    m_idx[1]   = ib.rk_idx;    m_idx[2]   = ic.rk_idx;
  end
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask
  function automatic logic [55:0] rot1(input logic [55:0] cd);
    return {cd[54:28], cd[55], cd[26:0], cd[27]};
  endfunction
  function automatic logic [47:0] pc2(input logic [55:0] cd);
    logic [47:0] o;
    for (int i = 0; i < 48; i++) o[47-i] = cd[56-P[i]];
    return o;
  endfunction
  function automatic logic [47:0] model(input int rounds, input logic [15:0] mask, input logic [55:0] k, input logic dec, input int i);
    int j;
    logic [55:0] cd;
    j = dec ? rounds - 1 - i : i;
    cd = k;
    for (int r = 0; r <= j; r++) begin
      cd = rot1(cd);
      if (!mask[r]) cd = rot1(cd);
    end
    return pc2(cd);
  endfunction
  task automatic wait_idle();
    int w;
    w = 0;
    while ((m_busy[0] || m_busy[1] || m_busy[2]) && w < 100) begin
      tick();
      w++;
    end
    chk("idle_wait", {m_busy[2], m_busy[1], m_busy[0]}, 0);
  endtask
  task automatic run(input int sel, input logic [55:0] k, input logic dec, input bit bp, input bit inj, input bit b2b);
    int n, cnt, stalls, iters;
    logic [47:0] sd;
    logic [3:0] si;
    bit stalled;
    n = sel == 0 ? 16 : sel == 1 ? 1 : 4;
    rk_ready = 1'b1;
    wait_idle();
    key_in = k;
    decrypt = dec;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("first_valid", m_valid[sel], 1);
    chk("first_busy", m_busy[sel], 1);
    cnt = 0; stalls = 0; iters = 0; stalled = 0; sd = '0; si = '0;
    while (cnt < n && iters < 200) begin
      if (stalled) begin
        chk("hold_data", m_data[sel], sd);
        chk("hold_idx", m_idx[sel], si);
      end
      rk_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      start = 1'b0;
      if (inj && m_valid[sel] && m_idx[sel] == 4'd5) begin
        start = 1'b1;
        key_in = ~k;
        decrypt = ~dec;
      end
      iters++;
      if (m_valid[sel] && rk_ready) begin
        got[cnt] = m_data[sel];
        chk("idx_order", m_idx[sel], cnt);
        chk("last_flag", m_last[sel], cnt == n - 1);
        cnt++;
        stalled = 0;
      end else begin
        stalled = m_valid[sel];
        sd = m_data[sel];
        si = m_idx[sel];
        stalls++;
      end
      tick();
    end
    start = 1'b0;
    rk_ready = 1'b1;
    chk("key_count", cnt, n);
    chk("cycles", iters, n + stalls);
    chk("done_pulse", m_done[sel], 1);
    chk("busy_after", m_busy[sel], 0);
    chk("valid_after", m_valid[sel], 0);
    if (b2b) begin
      key_in = K2;
      decrypt = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("b2b_valid", m_valid[sel], 1);
      chk("b2b_idx", m_idx[sel], 0);
      chk("b2b_key", m_data[sel], model(16, 16'h8103, K2, 1'b0, 0));
    end else begin
      tick();
      chk("done_once", m_done[sel], 0);
    end
  endtask
  initial begin
    n_vec = 0; n_bad = 0;
    rst = 1'b1; start = 1'b0; decrypt = 1'b0; key_in = '0; rk_ready = 1'b1;
    repeat (3) tick();
    chk("rst_valid", ia.rk_valid, 0);
    chk("rst_busy", ia.busy, 0);
    chk("rst_done", ia.done, 0);
    chk("rst_idx", ia.rk_idx, 0);
    chk("rst_cd", ia.cd_out, 0);
    chk("rst_data", ia.rk_data, 0);
    rst = 1'b0;
    tick();
    run(0, K, 1'b0, 0, 0, 0);
    chk("enc_k1", got[0], K1_E);
    chk("enc_k16", got[15], K16_E);
    for (int i = 0; i < 16; i++) begin
      enc[i] = got[i];
      chk("enc_model", got[i], model(16, 16'h8103, K, 1'b0, i));
    end
    chk("enc_cd_end", ia.cd_out, K);
    run(0, K, 1'b1, 0, 0, 0);
    chk("dec_first", got[0], K16_E);
    chk("dec_last", got[15], K1_E);
    for (int i = 0; i < 16; i++) chk("dec_reverse", got[i], enc[15-i]);
    chk("dec_cd_end", ia.cd_out, 56'hE19955FAACCF1E);
    wait_idle();
    key_in = K; decrypt = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int w = 0; w < 20 && ia.rk_idx != 4'd7; w++) tick();
    chk("reach_idx7", ia.rk_idx, 7);
    rst = 1'b1; start = 1'b1; key_in = K2;
    tick();
    rst = 1'b0; start = 1'b0;
    chk("abort_valid", ia.rk_valid, 0);
    chk("abort_busy", ia.busy, 0);
    chk("abort_done", ia.done, 0);
    chk("abort_idx", ia.rk_idx, 0);
    chk("abort_cd", ia.cd_out, 0);
    chk("abort_data", ia.rk_data, 0);
    chk("abort_last", ia.rk_last, 0);
    tick();
    chk("abort_no_done", ia.done, 0);
    chk("abort_idle", ia.busy, 0);
    run(0, K, 1'b0, 1, 0, 0);
    for (int i = 0; i < 16; i++) chk("bp_model", got[i], enc[i]);
    run(0, K, 1'b0, 0, 1, 1);
    for (int i = 0; i < 16; i++) chk("inj_model", got[i], enc[i]);
    run(1, K, 1'b0, 0, 0, 0);
    enc[0] = got[0];
    chk("r1_enc", got[0], model(1, 16'h0001, K, 1'b0, 0));
    run(1, K, 1'b1, 0, 0, 0);
    chk("r1_dec", got[0], model(1, 16'h0001, K, 1'b1, 0));
    chk("r1_reverse", got[0], enc[0]);
    run(2, K, 1'b0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      enc[i] = got[i];
      chk("r4_enc", got[i], model(4, 16'h0000, K, 1'b0, i));
    end
    run(2, K, 1'b1, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      chk("r4_dec", got[i], model(4, 16'h0000, K, 1'b1, i));
      chk("r4_reverse", got[i], enc[3-i]);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
